// File: rtl/percept_drv.sv
`default_nettype none
// ============================================================================
//  Module      : percept_drv
//  Description : Sequencer for a bit-serial perceptron cell. It accepts an
//                operand pair, shifts it serially into the cell, issues the
//                multiply and accumulate strobes, and on a "last" operand
//                serially reads out and clears the cell accumulator. The
//                assembled result is held for a valid/ready consumer.
//
//  Ports       : clk, rst              clock, synchronous active-high reset
//                op_valid/op_ready     operand handshake (ready only in IDLE)
//                op_a, op_b, op_last   operand pair and readout request
//                res_valid/res_ready   result handshake
//                res_data              accumulator readout, 4*SIZE bits
//                shift_in, shift_out,
//                mul, acc              cell command strobes (one-hot or zero)
//                cell_din              serial bit into the cell
//                cell_dout             serial bit out of the cell
//
//  Revision    : 1.0  initial release
// ============================================================================
module percept_drv #(
    parameter int SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [SIZE-1:0]       op_a,
    input  logic [SIZE-1:0]       op_b,
    input  logic                  op_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [4*SIZE-1:0]     res_data,
    output logic                  shift_in,
    output logic                  shift_out,
    output logic                  mul,
    output logic                  acc,
    output logic                  cell_din,
    input  logic                  cell_dout
);

    localparam int                C_CNT_W    = $clog2(4*SIZE);
    localparam logic [C_CNT_W-1:0] C_LOAD_END = C_CNT_W'(2*SIZE-1);
    localparam logic [C_CNT_W-1:0] C_READ_END = C_CNT_W'(4*SIZE-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_ACC   = 3'd3,
        S_READ  = 3'd4,
        S_DRAIN = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [2*SIZE-1:0]     r_sh;      // {op_b, op_a}; MSB is the next bit out
    logic                  r_last;
    logic                  r_cap;     // previous cycle was a shift_out cycle
    logic [4*SIZE-1:0]     r_res;
    logic                  w_op_fire;

    assign op_ready  = (r_state == S_IDLE);
    assign res_valid = (r_state == S_RESP);
    assign res_data  = r_res;
    assign w_op_fire = op_valid & op_ready;

    // Serial data is only driven while loading; zero otherwise.
    assign cell_din  = (r_state == S_LOAD) & r_sh[2*SIZE-1];

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        shift_in     = 1'b0;
        shift_out    = 1'b0;
        mul          = 1'b0;
        acc          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_in = 1'b1;
                if (r_cnt == C_LOAD_END) begin
                    w_next_state = S_MUL;
                end
            end
            S_MUL: begin
                mul          = 1'b1;
                w_next_state = S_ACC;
            end
            S_ACC: begin
                acc          = 1'b1;
                w_next_state = r_last ? S_READ : S_IDLE;
            end
            S_READ: begin
                shift_out = 1'b1;
                if (r_cnt == C_READ_END) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_last  <= 1'b0;
            r_cap   <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_next_state;

            // One counter serves both LOAD and READ; it wraps to zero at
            // the end of each phase and idles at zero elsewhere.
            if ((r_state == S_LOAD && r_cnt == C_LOAD_END) ||
                (r_state == S_READ && r_cnt == C_READ_END)) begin
                r_cnt <= '0;
            end else if (r_state == S_LOAD || r_state == S_READ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_op_fire) begin
                r_sh   <= {op_b, op_a};
                r_last <= op_last;
            end else if (r_state == S_LOAD) begin
                r_sh   <= {r_sh[2*SIZE-2:0], 1'b0};
            end

            // The cell registers its output bit on each shift_out edge, so
            // the bit is valid one cycle later; capture lags READ by one.
            r_cap <= (r_state == S_READ);
            if (r_cap) begin
                r_res <= {r_res[4*SIZE-2:0], cell_dout};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_percept_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_percept_drv
//  Description : Self-checking bench for percept_drv with a behavioural
//                perceptron cell and an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_percept_drv;

    localparam int S = 32;
    localparam int W = 4*S;

    logic           clk;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [S-1:0]   op_a;
    logic [S-1:0]   op_b;
    logic           op_last;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           shift_in;
    logic           shift_out;
    logic           mul;
    logic           acc;
    logic           cell_din;
    logic           cell_dout;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_onehot_prints = 0;
    logic [W-1:0]   model_acc = '0;

    percept_drv #(.SIZE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_last   (op_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .mul       (mul),
        .acc       (acc),
        .cell_din  (cell_din),
        .cell_dout (cell_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural perceptron cell ----------------
    // Serial chain {data_2, data_1}; product register; accumulator whose
    // MSB is registered onto data_out on each shift_out, zeros shifted in.
    logic [2*S-1:0] c_chain;
    logic [2*S-1:0] c_prod;
    logic [W-1:0]   c_acc;
    logic           c_dout;
    assign cell_dout = c_dout;

    always @(posedge clk) begin
        if (rst) begin
            c_chain <= '0;
            c_prod  <= '0;
            c_acc   <= '0;
            c_dout  <= 1'b0;
        end else begin
            if (shift_in)  c_chain <= {c_chain[2*S-2:0], cell_din};
            if (mul)       c_prod  <= {{S{1'b0}}, c_chain[S-1:0]} * {{S{1'b0}}, c_chain[2*S-1:S]};
            if (acc)       c_acc   <= c_acc + {{(W-2*S){1'b0}}, c_prod};
            if (shift_out) begin
                c_dout <= c_acc[W-1];
                c_acc  <= {c_acc[W-2:0], 1'b0};
            end
        end
    end

    // Strobes one-hot-or-zero and cell_din quiet outside loading, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ($countones({shift_in, shift_out, mul, acc}) > 1 || (cell_din && !shift_in)) begin
                n_fail++;
                if (n_onehot_prints < 10) begin
                    n_onehot_prints++;
                    $display("FAIL strobe_onehot: got si=%0b so=%0b mul=%0b acc=%0b din=%0b, required at most one strobe and din=0 outside shift_in",
                             shift_in, shift_out, mul, acc, cell_din);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_op(input logic [S-1:0] a, input logic [S-1:0] b,
                                              input logic last);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] r;
        ea = {{(W-S){1'b0}}, a};
        eb = {{(W-S){1'b0}}, b};
        model_acc = model_acc + ea * eb;   // wraps modulo 2^W
        r = model_acc;
        if (last) model_acc = '0;
        return r;
    endfunction

    // Drives one operand and observes until op_ready (non-last) or res_valid
    // (last). lat is the cycle number, handshake edge ending cycle 0.
    task automatic run_op(input logic [S-1:0] a, input logic [S-1:0] b, input logic last,
                          output int lat, output logic [W-1:0] res,
                          output int n_si, output int n_mu, output int n_ac, output int n_so);
        int guard;
        lat = -1; res = '0; n_si = 0; n_mu = 0; n_ac = 0; n_so = 0;
        guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        op_a = a; op_b = b; op_last = last; op_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) op_valid = 1'b0;
            n_si += int'(shift_in);
            n_mu += int'(mul);
            n_ac += int'(acc);
            n_so += int'(shift_out);
            if (!last && op_ready) begin lat = k; break; end
            if (last && res_valid) begin lat = k; res = res_data; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_last = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got valid=%0b data=%h, required 0/0", res_valid, res_data);
        end
        n_checks++;
        if ({shift_in, shift_out, mul, acc, cell_din} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, required 00000", {shift_in, shift_out, mul, acc, cell_din});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b, required 1", op_ready);
        end
        model_acc = '0;
    endtask

    task automatic test_basic();
        int lat, si, mu, ac, so;
        logic [W-1:0] res, exp;
        exp = model_op(32'd3, 32'd5, 1'b1);
        run_op(32'd3, 32'd5, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (lat !== 6*S+4) begin
            n_fail++; $display("FAIL basic_latency: got %0d, required %0d", lat, 6*S+4);
        end
        n_checks++;
        if (res !== exp || exp !== 128'd15) begin
            n_fail++; $display("FAIL basic_result: got %h, required %h", res, 128'd15);
        end
        n_checks++;
        if (si != 2*S || mu != 1 || ac != 1 || so != 4*S) begin
            n_fail++; $display("FAIL basic_counts: got si=%0d mul=%0d acc=%0d so=%0d, required 64/1/1/128", si, mu, ac, so);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_accept: got valid=%0b ready=%0b, required 0/1", res_valid, op_ready);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int lat, si, mu, ac, so;
        logic [W-1:0] res, exp;
        exp = model_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, res, si, mu, ac, so);
        n_checks++;
        if (lat !== 2*S+3) begin
            n_fail++; $display("FAIL nolast_ready_latency: got %0d, required %0d", lat, 2*S+3);
        end
        n_checks++;
        if (si != 2*S || mu != 1 || ac != 1 || so != 0) begin
            n_fail++; $display("FAIL nolast_counts: got si=%0d mul=%0d acc=%0d so=%0d, required 64/1/1/0", si, mu, ac, so);
        end
        exp = model_op(32'd2, 32'd7, 1'b1);
        run_op(32'd2, 32'd7, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (res !== exp || exp !== 128'hFFFF_FFFE_0000_000F) begin
            n_fail++; $display("FAIL accum_result: got %h, required %h", res, 128'hFFFF_FFFE_0000_000F);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, si, mu, ac, so;
        logic [W-1:0] res, exp;
        exp = model_op(32'd4, 32'd4, 1'b1);
        run_op(32'd4, 32'd4, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (res !== exp || exp !== 128'd16) begin
            n_fail++; $display("FAIL b2b_first: got %h, required %h", res, 128'd16);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp = model_op(32'd6, 32'd1, 1'b1);
        run_op(32'd6, 32'd1, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (res !== exp || exp !== 128'd6) begin
            n_fail++; $display("FAIL b2b_second: got %h, required %h", res, 128'd6);
        end
        n_checks++;
        if (lat !== 6*S+4 || so != 4*S) begin
            n_fail++; $display("FAIL b2b_timing: got lat=%0d so=%0d, required %0d/%0d", lat, so, 6*S+4, 4*S);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, si, mu, ac, so;
        logic [W-1:0] res, exp;
        logic [S-1:0] a, b;
        int bad;
        a = $urandom; b = $urandom;
        exp = model_op(a, b, 1'b1);
        run_op(a, b, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (res !== exp) begin
            n_fail++; $display("FAIL bp_result: got %h, required %h", res, exp);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            op_valid = 1'b1; op_a = $urandom; op_b = $urandom; op_last = 1'b1;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== exp || op_ready !== 1'b0 ||
                {shift_in, shift_out, mul, acc} !== 4'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
        end
        op_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_accept: got valid=%0b ready=%0b, required 0/1", res_valid, op_ready);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat, si, mu, ac, so, guard;
        logic [W-1:0] res, exp;
        guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 400) begin @(negedge clk); guard++; end
        op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; op_last = 1'b1; op_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        n_checks++;
        if (shift_in !== 1'b1) begin
            n_fail++; $display("FAIL abort_in_load: got shift_in=%0b, required 1", shift_in);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({shift_in, shift_out, mul, acc, cell_din} !== 5'b0) begin
            n_fail++; $display("FAIL abort_strobes: got %b, required 00000", {shift_in, shift_out, mul, acc, cell_din});
        end
        rst = 1'b0;
        model_acc = '0;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %0b, required 1", op_ready);
        end
        exp = model_op(32'd3, 32'd5, 1'b1);
        run_op(32'd3, 32'd5, 1'b1, lat, res, si, mu, ac, so);
        n_checks++;
        if (res !== exp || exp !== 128'd15) begin
            n_fail++; $display("FAIL abort_fresh: got %h, required %h", res, 128'd15);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat, si, mu, ac, so, dly;
        logic [W-1:0] res, exp;
        logic [S-1:0] a, b;
        logic last;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            last = (i == 9) || ($urandom_range(0, 2) == 0);
            exp = model_op(a, b, last);
            run_op(a, b, last, lat, res, si, mu, ac, so);
            n_checks++;
            if (lat !== (last ? 6*S+4 : 2*S+3)) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, lat, last ? 6*S+4 : 2*S+3);
            end
            n_checks++;
            if (si != 2*S || mu != 1 || ac != 1 || so != (last ? 4*S : 0)) begin
                n_fail++; $display("FAIL rand_counts[%0d]: got si=%0d mul=%0d acc=%0d so=%0d", i, si, mu, ac, so);
            end
            if (last) begin
                n_checks++;
                if (res !== exp) begin
                    n_fail++; $display("FAIL rand_result[%0d]: got %h, required %h", i, res, exp);
                end
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== exp) begin
                    n_fail++; $display("FAIL rand_hold[%0d]: got valid=%0b data=%h, required 1/%h", i, res_valid, res_data, exp);
                end
                res_ready = 1'b1;
                @(negedge clk);
                res_ready = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_last = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
